rate_pulse_generator: RTL

- Upstream neighbour of the 8-bit T-flip-flop counter.
- Divides the 50 MHz board clock into a one-cycle enable pulse at a switch-selected rate.
- `pulse` drives the counter's `enable`, so the counter advances once per selected period rather than on every KEY press or every clock.
- Also exposes the current divider count for debug and display.

---
 rtl/rate_pulse_generator_pkg.sv | 21 ++
 rtl/rate_divisor_select.sv | 39 +++
 rtl/rate_pulse_generator.sv | 84 ++++++++
 3 files changed

// File: rtl/rate_pulse_generator_pkg.sv
// -----------------------------------------------------------------------------
// rate_pulse_generator_pkg
// Shared definitions for the rate pulse generator: the rate-select encodings
// and the divisor multiplier applied to CLK_FREQ for each encoding.
// -----------------------------------------------------------------------------
package rate_pulse_generator_pkg;

  // Rate-select encodings driven from the board switches.
  localparam logic [1:0] RATE_FULL    = 2'b00;  // every clock cycle
  localparam logic [1:0] RATE_1HZ     = 2'b01;  // CLK_FREQ cycles
  localparam logic [1:0] RATE_HALF    = 2'b10;  // 2*CLK_FREQ cycles
  localparam logic [1:0] RATE_QUARTER = 2'b11;  // 4*CLK_FREQ cycles

  // Divisor multipliers. RATE_FULL also carries 1, but its divisor is a
  // literal 1 rather than 1*CLK_FREQ.
  localparam int unsigned MULT_FULL    = 1;
  localparam int unsigned MULT_1HZ     = 1;
  localparam int unsigned MULT_HALF    = 2;
  localparam int unsigned MULT_QUARTER = 4;

endpackage : rate_pulse_generator_pkg

// File: rtl/rate_divisor_select.sv
// -----------------------------------------------------------------------------
// rate_divisor_select
// Combinational map from the rate select to the divider reload value N-1.
//
// Ports:
//   sel   in   2      rate select (RATE_* encodings)
//   load  out  WIDTH  N(sel)-1, the value the down-counter reloads with
// -----------------------------------------------------------------------------
module rate_divisor_select
  import rate_pulse_generator_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned WIDTH    = 28
) (
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] load
);

  // Reload constants are formed in 64-bit arithmetic before narrowing, so the
  // 4*CLK_FREQ product cannot wrap before it is cut down to WIDTH bits.
  localparam logic [WIDTH-1:0] LOAD_FULL    = WIDTH'(64'(MULT_FULL) - 64'd1);
  localparam logic [WIDTH-1:0] LOAD_1HZ     = WIDTH'(64'(MULT_1HZ) * 64'(CLK_FREQ) - 64'd1);
  localparam logic [WIDTH-1:0] LOAD_HALF    = WIDTH'(64'(MULT_HALF) * 64'(CLK_FREQ) - 64'd1);
  localparam logic [WIDTH-1:0] LOAD_QUARTER = WIDTH'(64'(MULT_QUARTER) * 64'(CLK_FREQ) - 64'd1);

  // NOTE: a default assignment ahead of the case keeps this block free of
  // inferred latches even if the case is later edited to be incomplete.
  always_comb begin
    load = LOAD_FULL;
    case (sel)
      RATE_FULL:    load = LOAD_FULL;
      RATE_1HZ:     load = LOAD_1HZ;
      RATE_HALF:    load = LOAD_HALF;
      RATE_QUARTER: load = LOAD_QUARTER;
      default:      load = LOAD_FULL;
    endcase
  end

endmodule : rate_divisor_select

// File: rtl/rate_pulse_generator.sv
// -----------------------------------------------------------------------------
// rate_pulse_generator
// Divides the board clock into a registered one-cycle enable pulse at a
// switch-selected rate, feeding the enable of the downstream counter.
//
// Ports:
//   clock    in   1      system clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   enable   in   1      advance enable; low freezes the divider phase
//   sel      in   2      rate select (00 full, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz)
//   restart  in   1      synchronous reload of the divider to N(sel)-1
//   pulse    out  1      registered one-cycle enable pulse
//   count    out  WIDTH  current divider value (counts down)
// -----------------------------------------------------------------------------
module rate_pulse_generator
  import rate_pulse_generator_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned WIDTH    = 28
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       sel,
  input  logic             restart,
  output logic             pulse,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [1:0]       r_sel_q;
  logic             r_first;
  logic             r_pulse;

  logic [WIDTH-1:0] w_load;
  logic             w_sel_change;

  rate_divisor_select #(
    .CLK_FREQ (CLK_FREQ),
    .WIDTH    (WIDTH)
  ) u_divisor (
    .sel  (sel),
    .load (w_load)
  );

  // The first edge after reset only captures sel; it must not be mistaken
  // for a select change against the arbitrary 00 reset value of r_sel_q.
  assign w_sel_change = (sel != r_sel_q) && !r_first;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_sel_q <= RATE_FULL;
      r_first <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_first <= 1'b0;
      // Outside rules 1/2 sel already equals r_sel_q (or this is the first
      // edge), so tracking sel unconditionally is equivalent and simpler.
      r_sel_q <= sel;
      if (restart || w_sel_change) begin
        // Restart and select change collapse into a single reload, no pulse.
        r_count <= w_load;
        r_pulse <= 1'b0;
      end else if (!enable) begin
        r_pulse <= 1'b0;
      end else if (r_count == '0) begin
        // Terminal count: reload and fire. Zero always reloads, so the
        // counter can never underflow.
        r_count <= w_load;
        r_pulse <= 1'b1;
      end else begin
        r_count <= r_count - 1'b1;
        r_pulse <= 1'b0;
      end
    end
  end

  assign pulse = r_pulse;
  assign count = r_count;

endmodule : rate_pulse_generator
